display_scan8: RTL and testbench
================================

# display_scan8

Time-multiplexed driver for the board's 8-digit common-anode seven-segment display. It sits directly downstream of the display manager and consumes its eight 6-bit digit codes `d1`..`d8`, each formatted `{anode_off, code[3:0], dp}`. It samples all eight codes once per frame into shadow registers so the display never tears mid-frame. It then scans one digit per slot, with a programmable blanking interval against ghosting, and drives registered active-low anode and segment lines.

## Interface
- `CLK_DIV`, default 100000: clock cycles per digit slot. Must be ≥ 2.
- `BLANK_CYC`, default 1000: cycles at the start of each slot with all anodes off. Must satisfy 0 ≤ `BLANK_CYC` < `CLK_DIV`.
- `clock`, in, 1: system clock. All state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `d1`..`d8`, in, 6 each: digit codes. `d1` is the leftmost digit and `d8` the rightmost.
  - bit 5 = 1 blanks the digit.
  - bits 4:1 = font code.
  - bit 0 = 1 lights the decimal point.
- `an`, out, 8: anodes, active-low. `an[7]` is the leftmost digit and `an[0]` the rightmost.
- `dec_ddp`, out, 8: cathodes, active-low. Bits [7:1] = segments a..g, bit [0] = dp.
- `frame_tick`, out, 1: one-cycle pulse after each shadow capture.

## Operation
- Slot counter `cnt` runs 0..`CLK_DIV`-1 and wraps to 0.
- Digit index `idx` runs 0..7. It advances on the edge where `cnt`=`CLK_DIV`-1, and wraps from 7 to 0.
- Slot `idx`=k displays shadow register k+1 (`d1` at k=0) on `an[7-k]`.
- Shadow capture:
  - All eight shadow registers load `d1`..`d8` on the single edge where `cnt`=`CLK_DIV`-1 and `idx`=7, i.e. the end of the frame.
  - Input changes at any other time have no effect until the next capture.
- Output function, computed from the pre-edge `cnt`, `idx` and shadow values:
  - If `cnt` < `BLANK_CYC`, or the shadow's bit 5 = 1: `an`=8'hFF and `dec_ddp`=8'hFF.
  - Otherwise: `an` has only bit 7-`idx` low. `dec_ddp[7:1]` = inverted font pattern. `dec_ddp[0]` = inverse of shadow bit 0.
- Font, pattern abcdefg with 1 = segment lit:
  - 0 "0/O" 1111110
  - 1 "1" 0110000
  - 2 "2" 1101101
  - 3 "3" 1111001
  - 4 "4/Y" 0110011
  - 5 "5/S" 1011011
  - 6 "G" 1011110
  - 7 "t" 0001111
  - 8 "8/B" 1111111
  - 9 "L" 0001110
  - A "A" 1110111
  - B "J" 0111100
  - C "U" 0111110
  - D "P" 1100111
  - E "E" 1001111
  - F blank 0000000
- Reset (`reset`=0, asynchronous):
  - `cnt`=0 and `idx`=0.
  - All shadows = 6'b100000 (blank).
  - `an`=8'hFF, `dec_ddp`=8'hFF, `frame_tick`=0.
  - Assertion mid-frame forces these values immediately, without waiting for a clock edge.

## Timing
- `an`, `dec_ddp` and `frame_tick` are registered. They reflect counter/shadow state with 1-cycle latency.
- One frame lasts 8×`CLK_DIV` cycles.
- The first frame after reset release shows all digits blank, because the shadows are still at their reset value. The first captured values appear in frame 2.
- `frame_tick`=1 for exactly one cycle, the cycle after the capture edge. Its first assertion comes 8×`CLK_DIV` cycles after reset release.
- Input latency: a value present at a capture edge reaches the anodes of digit k no earlier than k×`CLK_DIV`+`BLANK_CYC`+1 cycles after that edge.
- `BLANK_CYC`=0 disables blanking: the digit is lit for the full slot.
- The slot boundary and the frame capture on the same edge are legal. The capture and the `idx` wrap happen together, so the new slot 0 uses the new shadow 1.

## Test plan
- Run with `CLK_DIV`=4, `BLANK_CYC`=1 throughout.
- Reset hold: drive `reset`=0 with all `d` = 6'b000010. Required: `an`=FF, `dec_ddp`=FF, `frame_tick`=0. After release, `an`=FF for the full first 32 cycles.
- Scan order: after the first capture with `d1`..`d8` = codes 0..7 (bit 5 = 0, bit 0 = 0):
  - `an` steps 7F, BF, DF, EF, F7, FB, FD, FE.
  - Each digit is low for 3 cycles, preceded by 1 cycle of FF.
  - `dec_ddp` for `d1` = 8'b00000011 (font "0", dp off).
- No tearing: change `d1` to code 8 in mid-frame. Required: digit 7 keeps showing "0" until the next `frame_tick`, then shows `dec_ddp`=8'b00000001.
- Blank and decimal point:
  - `d3` = 6'b100001: `an[5]` stays high for the whole slot.
  - `d4` = 6'b000101 (code 2, dp on): `dec_ddp` = 8'b00100100 when `an`=EF.
- Async reset mid-scan: pull `reset` low while `an`=DF, between clock edges. Required: `an`=FF and `dec_ddp`=FF immediately. After release, the scan restarts at `idx` 0 with a blank first frame.

Source files
------------

// File: rtl/display_scan8.sv
// Time-multiplexed scanner for an 8-digit common-anode seven-segment display.
// Inputs are captured once per frame into shadow registers; outputs are registered and active-low.
module display_scan8 #(
  parameter int CLK_DIV   = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] d1,
  input  logic [5:0] d2,
  input  logic [5:0] d3,
  input  logic [5:0] d4,
  input  logic [5:0] d5,
  input  logic [5:0] d6,
  input  logic [5:0] d7,
  input  logic [5:0] d8,
  output logic [7:0] an,
  output logic [7:0] dec_ddp,
  output logic       frame_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       idx_reg, idx_next;
  logic [5:0]       d_in [8];
  logic [5:0]       shadow_reg [8];
  logic             slot_end, frame_end;
  logic [7:0]       an_reg, an_next;
  logic [7:0]       dec_ddp_reg, dec_ddp_next;
  logic             frame_tick_reg;
  logic [5:0]       cur_code;
  logic [6:0]       seg;

  assign d_in[0] = d1;
  assign d_in[1] = d2;
  assign d_in[2] = d3;
  assign d_in[3] = d4;
  assign d_in[4] = d5;
  assign d_in[5] = d6;
  assign d_in[6] = d7;
  assign d_in[7] = d8;

  assign slot_end  = (cnt_reg == CNT_MAX);
  assign frame_end = slot_end && (idx_reg == 3'd7);

  // Font pattern abcdefg, 1 = segment lit.
  function automatic logic [6:0] font(input logic [3:0] code);
    case (code)
      4'h0:    font = 7'b1111110;
      4'h1:    font = 7'b0110000;
      4'h2:    font = 7'b1101101;
      4'h3:    font = 7'b1111001;
      4'h4:    font = 7'b0110011;
      4'h5:    font = 7'b1011011;
      4'h6:    font = 7'b1011110;
      4'h7:    font = 7'b0001111;
      4'h8:    font = 7'b1111111;
      4'h9:    font = 7'b0001110;
      4'hA:    font = 7'b1110111;
      4'hB:    font = 7'b0111100;
      4'hC:    font = 7'b0111110;
      4'hD:    font = 7'b1100111;
      4'hE:    font = 7'b1001111;
      default: font = 7'b0000000;
    endcase
  endfunction

  always_comb begin
    cnt_next = slot_end ? '0 : cnt_reg + 1'b1;
    idx_next = slot_end ? idx_reg + 3'd1 : idx_reg;
  end

  always_comb begin
    cur_code     = shadow_reg[idx_reg];
    seg          = font(cur_code[4:1]);
    an_next      = 8'hFF;
    dec_ddp_next = 8'hFF;
    // Anodes stay off during the anti-ghosting window and for blanked digits.
    if (!(cnt_reg < BLANK_END) && !cur_code[5]) begin
      an_next      = ~(8'h80 >> idx_reg);
      dec_ddp_next = {~seg, ~cur_code[0]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
      idx_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
      idx_reg <= idx_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) shadow_reg[i] <= 6'b100000;
    end else if (frame_end) begin
      for (int i = 0; i < 8; i++) shadow_reg[i] <= d_in[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      an_reg         <= 8'hFF;
      dec_ddp_reg    <= 8'hFF;
      frame_tick_reg <= 1'b0;
    end else begin
      an_reg         <= an_next;
      dec_ddp_reg    <= dec_ddp_next;
      frame_tick_reg <= frame_end;
    end
  end

  assign an         = an_reg;
  assign dec_ddp    = dec_ddp_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_display_scan8.sv
// Directed bench for display_scan8 with CLK_DIV=4, BLANK_CYC=1; outputs sampled on the falling edge.
module tb_display_scan8;

  localparam int CLK_DIV   = 4;
  localparam int BLANK_CYC = 1;

  logic       clock;
  logic       reset;
  logic [5:0] d [8];
  logic [7:0] an;
  logic [7:0] dec_ddp;
  logic       frame_tick;

  int checks   = 0;
  int failures = 0;

  logic [6:0] font_tab [16];
  logic [7:0] an_tab [8];
  logic [5:0] shown [8];

  display_scan8 #(
    .CLK_DIV  (CLK_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .d1        (d[0]),
    .d2        (d[1]),
    .d3        (d[2]),
    .d4        (d[3]),
    .d5        (d[4]),
    .d6        (d[5]),
    .d7        (d[6]),
    .d8        (d[7]),
    .an        (an),
    .dec_ddp   (dec_ddp),
    .frame_tick(frame_tick)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic test_reset;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) d[i] = 6'b000010;
    repeat (3) @(negedge clock);
    checks++;
    if (an !== 8'hFF) begin failures++; $display("FAIL reset_an actual=%h required=ff", an); end
    checks++;
    if (dec_ddp !== 8'hFF) begin failures++; $display("FAIL reset_dec actual=%h required=ff", dec_ddp); end
    checks++;
    if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick actual=%b required=0", frame_tick); end
    $display("reset hold: an=%h dec_ddp=%h frame_tick=%b", an, dec_ddp, frame_tick);
    for (int i = 0; i < 8; i++) d[i] = {1'b0, 4'(i), 1'b0};
    reset = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clock);
      checks++;
      if (an !== 8'hFF) begin failures++; $display("FAIL first_frame_an cycle=%0d actual=%h required=ff", c, an); end
      checks++;
      if (frame_tick !== (c == 32)) begin
        failures++; $display("FAIL first_frame_tick cycle=%0d actual=%b required=%b", c, frame_tick, (c == 32));
      end
    end
    for (int i = 0; i < 8; i++) shown[i] = d[i];
    $display("first frame blank, frame_tick after 32 cycles");
  endtask

  task automatic test_scan_order;
    int s, pos;
    logic blank;
    logic [7:0] exp_an, exp_dec;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clock);
      s = (k - 1) / 4;
      pos = (k - 1) % 4;
      blank = (pos < BLANK_CYC) || shown[s][5];
      exp_an = blank ? 8'hFF : an_tab[s];
      exp_dec = blank ? 8'hFF : {~font_tab[shown[s][4:1]], ~shown[s][0]};
      checks++;
      if (an !== exp_an) begin failures++; $display("FAIL scan_an k=%0d actual=%h required=%h", k, an, exp_an); end
      checks++;
      if (dec_ddp !== exp_dec) begin failures++; $display("FAIL scan_dec k=%0d actual=%h required=%h", k, dec_ddp, exp_dec); end
      checks++;
      if (frame_tick !== (k == 32)) begin failures++; $display("FAIL scan_tick k=%0d actual=%b required=%b", k, frame_tick, (k == 32)); end
      if (k == 2) begin
        checks++;
        if (dec_ddp !== 8'b00000011) begin failures++; $display("FAIL scan_d1_font actual=%b required=00000011", dec_ddp); end
      end
    end
    for (int i = 0; i < 8; i++) shown[i] = d[i];
    $display("scan order frame checked");
  endtask

  task automatic test_no_tearing;
    d[0] = 6'b010000;
    d[2] = 6'b100001;
    d[3] = 6'b000101;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clock);
      if (k >= 2 && k <= 4) begin
        checks++;
        if (an !== 8'h7F) begin failures++; $display("FAIL tear_an k=%0d actual=%h required=7f", k, an); end
        checks++;
        if (dec_ddp !== 8'b00000011) begin failures++; $display("FAIL tear_dec k=%0d actual=%b required=00000011", k, dec_ddp); end
      end
      checks++;
      if (frame_tick !== (k == 32)) begin failures++; $display("FAIL tear_tick k=%0d actual=%b required=%b", k, frame_tick, (k == 32)); end
    end
    for (int i = 0; i < 8; i++) shown[i] = d[i];
    $display("no tearing: d1 change held until next frame_tick");
  endtask

  task automatic test_blank_dp;
    int s, pos;
    logic blank;
    logic [7:0] exp_an, exp_dec;
    d[2] = 6'b000100;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clock);
      s = (k - 1) / 4;
      pos = (k - 1) % 4;
      blank = (pos < BLANK_CYC) || shown[s][5];
      exp_an = blank ? 8'hFF : an_tab[s];
      exp_dec = blank ? 8'hFF : {~font_tab[shown[s][4:1]], ~shown[s][0]};
      checks++;
      if (an !== exp_an) begin failures++; $display("FAIL bdp_an k=%0d actual=%h required=%h", k, an, exp_an); end
      checks++;
      if (dec_ddp !== exp_dec) begin failures++; $display("FAIL bdp_dec k=%0d actual=%h required=%h", k, dec_ddp, exp_dec); end
      if (s == 2) begin
        checks++;
        if (an[5] !== 1'b1) begin failures++; $display("FAIL bdp_an5_blank k=%0d actual=%b required=1", k, an[5]); end
      end
      if (k == 2) begin
        checks++;
        if (dec_ddp !== 8'b00000001) begin failures++; $display("FAIL bdp_d1_code8 actual=%b required=00000001", dec_ddp); end
      end
      if (k == 14) begin
        checks++;
        if (dec_ddp !== 8'b00100100) begin failures++; $display("FAIL bdp_d4_dp actual=%b required=00100100", dec_ddp); end
      end
    end
    for (int i = 0; i < 8; i++) shown[i] = d[i];
    $display("blank digit 3 and dp on digit 4 checked");
  endtask

  task automatic test_async_reset;
    for (int k = 1; k <= 10; k++) @(negedge clock);
    checks++;
    if (an !== 8'hDF) begin failures++; $display("FAIL async_pre_an actual=%h required=df", an); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (an !== 8'hFF) begin failures++; $display("FAIL async_an actual=%h required=ff", an); end
    checks++;
    if (dec_ddp !== 8'hFF) begin failures++; $display("FAIL async_dec actual=%h required=ff", dec_ddp); end
    checks++;
    if (frame_tick !== 1'b0) begin failures++; $display("FAIL async_tick actual=%b required=0", frame_tick); end
    $display("async reset mid-scan: an=%h dec_ddp=%h", an, dec_ddp);
    @(negedge clock);
    reset = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clock);
      checks++;
      if (an !== 8'hFF) begin failures++; $display("FAIL restart_an cycle=%0d actual=%h required=ff", c, an); end
      checks++;
      if (frame_tick !== (c == 32)) begin failures++; $display("FAIL restart_tick cycle=%0d actual=%b required=%b", c, frame_tick, (c == 32)); end
    end
    repeat (2) @(negedge clock);
    checks++;
    if (an !== 8'h7F) begin failures++; $display("FAIL restart_idx0_an actual=%h required=7f", an); end
    checks++;
    if (dec_ddp !== 8'b00000001) begin failures++; $display("FAIL restart_idx0_dec actual=%b required=00000001", dec_ddp); end
    $display("scan restarted at idx 0 after blank frame");
  endtask

  initial begin
    font_tab[0]  = 7'b1111110; font_tab[1]  = 7'b0110000;
    font_tab[2]  = 7'b1101101; font_tab[3]  = 7'b1111001;
    font_tab[4]  = 7'b0110011; font_tab[5]  = 7'b1011011;
    font_tab[6]  = 7'b1011110; font_tab[7]  = 7'b0001111;
    font_tab[8]  = 7'b1111111; font_tab[9]  = 7'b0001110;
    font_tab[10] = 7'b1110111; font_tab[11] = 7'b0111100;
    font_tab[12] = 7'b0111110; font_tab[13] = 7'b1100111;
    font_tab[14] = 7'b1001111; font_tab[15] = 7'b0000000;
    an_tab[0] = 8'h7F; an_tab[1] = 8'hBF; an_tab[2] = 8'hDF; an_tab[3] = 8'hEF;
    an_tab[4] = 8'hF7; an_tab[5] = 8'hFB; an_tab[6] = 8'hFD; an_tab[7] = 8'hFE;

    test_reset();
    test_scan_order();
    test_no_tearing();
    test_blank_dp();
    test_async_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
